regfile_mp: RTL and testbench

//  Parametrised multi-read-port register file for the pipelined processor; replaces the fixed 32x32, 2-read file.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_read_port.sv | 51 +++++
 rtl/regfile_mp.sv | 94 +++++++++
 tb/tb_regfile_mp.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and slice helpers for the multi-port register file.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NREGS  = 1 << DEF_ADDR_W;
    localparam int MAX_NRD    = 4;

    // Low bit of a port's field inside a flattened multi-port bus.
    function automatic int slice_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One synchronous read port: zero/bypass data select, busy lookup, output registers.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NREGS    = 1 << ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] regs [NREGS],
    input  logic [NREGS-1:0]  busy,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_busy
);

    logic              wr_hit;
    logic [DATA_W-1:0] next_data;
    logic              next_busy;

    always_comb begin
        wr_hit = wr_en && (wr_addr == addr);
        if ((ZERO_REG != 0) && (addr == '0)) begin
            next_data = '0;
        end else if ((BYPASS != 0) && wr_hit) begin
            next_data = wr_data;
        end else begin
            next_data = regs[addr];
        end
        // A release landing this edge already counts as free, even without bypassed data.
        next_busy = busy[addr] && !wr_hit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
            rd_busy <= 1'b0;
        end else if (rd_en) begin
            rd_data <= next_data;
            rd_busy <= next_busy;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with write bypass and busy scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd_en,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    output logic                  rd_valid,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  claim_en,
    input  logic [ADDR_W-1:0]     claim_addr,
    output logic [(1<<ADDR_W)-1:0] busy_vec
);

    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy;
    logic              wr_allowed;

    assign wr_allowed = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_allowed) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // New claim beats a same-edge release so the next writer stays tracked.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (claim_en && (claim_addr == ADDR_W'(i))) begin
                    busy[i] <= 1'b1;
                end else if (wr_en && (wr_addr == ADDR_W'(i))) begin
                    busy[i] <= 1'b0;
                end
            end
            if (ZERO_REG != 0) begin
                busy[0] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
        end
    end

    assign busy_vec = busy;

    for (genvar p = 0; p < NRD; p++) begin : g_port
        regfile_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .NREGS    (NREGS),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_port (
            .clk     (clk),
            .reset   (reset),
            .rd_en   (rd_en),
            .addr    (rd_addr[slice_lo(p, ADDR_W) +: ADDR_W]),
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .regs    (regs),
            .busy    (busy),
            .rd_data (rd_data[slice_lo(p, DATA_W) +: DATA_W]),
            .rd_busy (rd_busy[p])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Two builds (zero-reg+bypass, and neither) on shared stimulus, checked against a behavioural model.
module tb_regfile_mp;

    logic        clk;
    logic        reset;
    logic        rd_en;
    logic [19:0] rd_addr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        claim_en;
    logic [4:0]  claim_addr;

    logic [127:0] d0_rd_data, d1_rd_data;
    logic [3:0]   d0_rd_busy, d1_rd_busy;
    logic         d0_rd_valid, d1_rd_valid;
    logic [31:0]  d0_busy_vec, d1_busy_vec;

    int checks = 0;
    int errors = 0;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(4), .ZERO_REG(1), .BYPASS(1)) dut0 (
        .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(d0_rd_data), .rd_busy(d0_rd_busy), .rd_valid(d0_rd_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr), .busy_vec(d0_busy_vec)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(4), .ZERO_REG(0), .BYPASS(0)) dut1 (
        .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(d1_rd_data), .rd_busy(d1_rd_busy), .rd_valid(d1_rd_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr), .busy_vec(d1_busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: instance 0 has r0 hardwired and bypass; instance 1 has neither.
    logic [31:0] m_regs [2][32];
    logic        m_busy [2][32];
    logic [31:0] e_data [2][4];
    logic        e_busy [2][4];
    logic        e_valid;

    always @(posedge clk or posedge reset) begin : model
        int  a;
        logic hit;
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 32; i++) begin
                    m_regs[k][i] = 32'h0;
                    m_busy[k][i] = 1'b0;
                end
                for (int p = 0; p < 4; p++) begin
                    e_data[k][p] = 32'h0;
                    e_busy[k][p] = 1'b0;
                end
            end
            e_valid = 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (rd_en) begin
                    for (int p = 0; p < 4; p++) begin
                        a   = int'(rd_addr[p*5 +: 5]);
                        hit = wr_en && (int'(wr_addr) == a);
                        if (k == 0 && a == 0)     e_data[k][p] = 32'h0;
                        else if (k == 0 && hit)   e_data[k][p] = wr_data;
                        else                      e_data[k][p] = m_regs[k][a];
                        e_busy[k][p] = m_busy[k][a] && !hit;
                    end
                end
                if (wr_en && !(k == 0 && wr_addr == 5'd0)) m_regs[k][wr_addr] = wr_data;
                if (wr_en)    m_busy[k][wr_addr] = 1'b0;
                if (claim_en) m_busy[k][claim_addr] = 1'b1;
                if (k == 0)   m_busy[k][0] = 1'b0;
            end
            e_valid = rd_en;
        end
    end

    always @(negedge clk) begin : compare
        logic [31:0] exp_vec;
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 4; p++) begin
                check($sformatf("dut%0d rd_data[%0d]", k, p),
                      (k == 0) ? d0_rd_data[p*32 +: 32] : d1_rd_data[p*32 +: 32], e_data[k][p]);
                check($sformatf("dut%0d rd_busy[%0d]", k, p),
                      (k == 0) ? d0_rd_busy[p] : d1_rd_busy[p], e_busy[k][p]);
            end
            for (int i = 0; i < 32; i++) exp_vec[i] = m_busy[k][i];
            check($sformatf("dut%0d busy_vec", k), (k == 0) ? d0_busy_vec : d1_busy_vec, exp_vec);
            check($sformatf("dut%0d rd_valid", k), (k == 0) ? d0_rd_valid : d1_rd_valid, e_valid);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en = 1'b0; wr_en = 1'b0; claim_en = 1'b0;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1,
                          input logic [4:0] a2, input logic [4:0] a3);
        rd_en   = 1'b1;
        rd_addr = {a3, a2, a1, a0};
    endtask

    task automatic do_wr(input logic [4:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
    endtask

    task automatic do_claim(input logic [4:0] a);
        claim_en = 1'b1; claim_addr = a;
    endtask

    initial begin
        reset = 1'b1;
        rd_addr = '0; wr_addr = '0; wr_data = '0; claim_addr = '0;
        idle();
        step(); step();
        check("reset busy_vec", d0_busy_vec, 32'h0);
        check("reset rd_valid", d0_rd_valid, 1'b0);
        check("reset rd_data", d0_rd_data, 128'h0);
        reset = 1'b0;
        step();

        // r3 write, then aliased read on all ports
        do_wr(5'd3, 32'hDEADBEEF);
        step();
        idle(); set_rd(5'd3, 5'd3, 5'd3, 5'd3);
        step();
        check("alias p0", d0_rd_data[31:0], 32'hDEADBEEF);
        check("alias p1", d0_rd_data[63:32], 32'hDEADBEEF);
        check("alias rd_valid", d0_rd_valid, 1'b1);
        idle();
        step();
        check("rd_valid pulse", d0_rd_valid, 1'b0);
        check("hold p0", d0_rd_data[31:0], 32'hDEADBEEF);

        // bypass vs read-before-write
        do_wr(5'd7, 32'h11);
        step();
        do_wr(5'd7, 32'h55); set_rd(5'd7, 5'd7, 5'd7, 5'd7);
        step();
        check("bypass on", d0_rd_data[31:0], 32'h55);
        check("bypass off", d1_rd_data[31:0], 32'h11);
        idle(); set_rd(5'd7, 5'd7, 5'd7, 5'd7);
        step();
        check("bypass off reread", d1_rd_data[31:0], 32'h55);

        // r0 hardwiring
        idle(); do_wr(5'd0, 32'hFFFF); do_claim(5'd0);
        step();
        idle(); set_rd(5'd0, 5'd0, 5'd0, 5'd0);
        step();
        check("zero r0 data", d0_rd_data[31:0], 32'h0);
        check("zero r0 busy", d0_busy_vec[0], 1'b0);
        check("plain r0 data", d1_rd_data[31:0], 32'hFFFF);
        check("plain r0 busy", d1_busy_vec[0], 1'b1);
        check("plain r0 rd_busy", d1_rd_busy[0], 1'b1);

        // claim then release of r9
        idle(); do_claim(5'd9);
        step();
        idle(); set_rd(5'd9, 5'd9, 5'd9, 5'd9);
        step();
        check("r9 rd_busy claimed", d0_rd_busy[0], 1'b1);
        idle(); do_wr(5'd9, 32'd4); set_rd(5'd9, 5'd9, 5'd9, 5'd9);
        step();
        check("r9 rd_busy released", d0_rd_busy[0], 1'b0);
        check("r9 bypass data", d0_rd_data[31:0], 32'd4);
        check("r9 busy_vec", d0_busy_vec[9], 1'b0);
        check("r9 no-bypass data", d1_rd_data[31:0], 32'd0);

        // same-edge claim and release of r12
        idle(); do_claim(5'd12); do_wr(5'd12, 32'hABC);
        step();
        check("r12 claim wins", d0_busy_vec[12], 1'b1);
        check("r12 claim wins b", d1_busy_vec[12], 1'b1);

        // asynchronous reset mid-run with r5=7 busy
        idle(); do_wr(5'd5, 32'd7); do_claim(5'd5);
        step();
        idle(); set_rd(5'd5, 5'd5, 5'd5, 5'd5);
        step();
        check("pre-reset r5", d0_rd_data[31:0], 32'd7);
        check("pre-reset busy5", d0_busy_vec[5], 1'b1);
        #2 reset = 1'b1;
        #1;
        check("async reset data", d0_rd_data, 128'h0);
        check("async reset busy", d0_busy_vec, 32'h0);
        check("async reset valid", d0_rd_valid, 1'b0);
        step();
        reset = 1'b0; idle();
        step();
        check("post-reset valid", d0_rd_valid, 1'b0);
        check("post-reset data", d0_rd_data, 128'h0);
        set_rd(5'd5, 5'd5, 5'd5, 5'd5);
        step();
        check("post-reset r5", d0_rd_data[31:0], 32'h0);

        // randomized traffic with aliasing and occasional reset
        for (int n = 0; n < 10000; n++) begin
            logic [4:0] a [4];
            for (int p = 0; p < 4; p++)
                a[p] = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            rd_en      = ($urandom_range(0, 3) != 0);
            rd_addr    = {a[3], a[2], a[1], a[0]};
            wr_en      = ($urandom_range(0, 1) != 0);
            wr_addr    = ($urandom_range(0, 1) != 0) ? a[$urandom_range(0, 3)] : 5'($urandom_range(0, 31));
            wr_data    = $urandom;
            claim_en   = ($urandom_range(0, 2) == 0);
            claim_addr = 5'($urandom_range(0, 7));
            reset      = ($urandom_range(0, 499) == 0);
            step();
        end
        reset = 1'b0; idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
